// File: rtl/dsp_instr_encoder_pkg.sv
// Shared opcode values, instruction field positions and encoder types for the
// program-load encoder and the instruction decoder.
package dsp_instr_encoder_pkg;

    localparam int INST_WORD_LEN = 32;

    localparam logic [5:0] OP_ADD     = 6'b000000;
    localparam logic [5:0] OP_ADD_I   = 6'b000001;
    localparam logic [5:0] OP_SQR     = 6'b001100;
    localparam logic [5:0] OP_SH_LO   = 6'b010110;
    localparam logic [5:0] OP_SH_HI   = 6'b011011;
    localparam logic [5:0] OP_JMP     = 6'b100000;
    localparam logic [5:0] OP_BEZ     = 6'b100001;
    localparam logic [5:0] OP_BNEZ    = 6'b100010;
    localparam logic [5:0] OP_BEQ     = 6'b100011;
    localparam logic [5:0] OP_LD      = 6'b110010;
    localparam logic [5:0] OP_ST      = 6'b110011;
    localparam logic [5:0] OP_LD_IMM  = 6'b110100;

    localparam int OP_MSB    = 31, OP_LSB    = 26;
    localparam int R1_MSB    = 25, R1_LSB    = 21;
    localparam int R2_MSB    = 20, R2_LSB    = 16;
    localparam int R3_MSB    = 15, R3_LSB    = 11;
    localparam int SHAMT_MSB = 10, SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5,  FUNCT_LSB = 0;
    localparam int LIT_MSB   = 15, LIT_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [3:0] {
        CLS_R3,
        CLS_I,
        CLS_SQR,
        CLS_SHIFT,
        CLS_JMP,
        CLS_BR,
        CLS_BEQ,
        CLS_MEM,
        CLS_ILL
    } op_class_e;

    function automatic op_class_e op_class(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b001000,
            6'b001010, 6'b001101, 6'b010000, 6'b010010, 6'b010100: return CLS_R3;
            6'b000001, 6'b000011, 6'b000101, 6'b000111, 6'b001001,
            6'b001011, 6'b010001, 6'b010011, 6'b010101:            return CLS_I;
            OP_SQR:                                                 return CLS_SQR;
            6'b010110, 6'b010111, 6'b011000,
            6'b011001, 6'b011010, 6'b011011:                        return CLS_SHIFT;
            OP_JMP:                                                 return CLS_JMP;
            OP_BEZ, OP_BNEZ:                                        return CLS_BR;
            OP_BEQ:                                                 return CLS_BEQ;
            OP_LD, OP_ST, OP_LD_IMM:                                return CLS_MEM;
            default:                                                return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/dsp_instr_encoder_if.sv
// Field-tuple input stream and instruction-memory write port of the encoder.
interface dsp_instr_encoder_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [4:0]        in_r1;
    logic [4:0]        in_r2;
    logic [4:0]        in_r3;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_lit;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;

    modport slave (
        input  in_valid, in_opcode, in_r1, in_r2, in_r3, in_shamt, in_funct, in_lit,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_opcode, in_r1, in_r2, in_r3, in_shamt, in_funct, in_lit,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/dsp_instr_encoder_pack.sv
// Combinational packer: places the fields an opcode uses into the instruction
// word, forces every unused field to zero and flags illegal opcodes.
module dsp_instr_pack
    import dsp_instr_encoder_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [4:0]  r1_i,
    input  logic [4:0]  r2_i,
    input  logic [4:0]  r3_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] lit_i,
    output logic [INST_WORD_LEN-1:0] word_o,
    output logic        legal_o
);
    op_class_e cls;
    logic use_r1, use_r2, use_r3, use_sh, use_fn, use_lit;

    assign cls = op_class(opcode_i);

    always_comb begin
        use_r1  = 1'b0;
        use_r2  = 1'b0;
        use_r3  = 1'b0;
        use_sh  = 1'b0;
        use_fn  = 1'b0;
        use_lit = 1'b0;
        legal_o = 1'b1;
        case (cls)
            CLS_R3:    begin use_r1 = 1'b1; use_r2 = 1'b1; use_r3 = 1'b1; use_sh = 1'b1; use_fn = 1'b1; end
            CLS_I:     begin use_r1 = 1'b1; use_r2 = 1'b1; use_lit = 1'b1; end
            CLS_SQR:   begin use_r1 = 1'b1; use_r3 = 1'b1; end
            CLS_SHIFT: begin use_r1 = 1'b1; use_r3 = 1'b1; use_sh = 1'b1; use_fn = 1'b1; end
            CLS_JMP:   use_lit = 1'b1;
            CLS_BR:    begin use_r1 = 1'b1; use_lit = 1'b1; end
            CLS_BEQ:   begin use_r1 = 1'b1; use_r2 = 1'b1; use_lit = 1'b1; end
            CLS_MEM:   begin use_r1 = 1'b1; use_r2 = 1'b1; end
            default:   legal_o = 1'b0;
        endcase
    end

    // The literal overlaps R3/shamt/funct; no class uses both, so order is irrelevant.
    always_comb begin
        word_o = '0;
        word_o[OP_MSB:OP_LSB] = opcode_i;
        if (use_r1)  word_o[R1_MSB:R1_LSB]       = r1_i;
        if (use_r2)  word_o[R2_MSB:R2_LSB]       = r2_i;
        if (use_r3)  word_o[R3_MSB:R3_LSB]       = r3_i;
        if (use_sh)  word_o[SHAMT_MSB:SHAMT_LSB] = shamt_i;
        if (use_fn)  word_o[FUNCT_MSB:FUNCT_LSB] = funct_i;
        if (use_lit) word_o[LIT_MSB:LIT_LSB]     = lit_i;
    end
endmodule

// File: rtl/dsp_instr_encoder.sv
// Program-load encoder: packs field tuples into instruction words and writes
// them to consecutive instruction-memory addresses, one word per two cycles.
module dsp_instr_encoder
    import dsp_instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    dsp_instr_encoder_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] word_count
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [INST_W-1:0] word_q, word_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [ADDR_W-1:0] cnt_inc;
    logic [INST_W-1:0] packed_word;
    logic              packed_legal;

    dsp_instr_pack u_pack (
        .opcode_i (bus.in_opcode),
        .r1_i     (bus.in_r1),
        .r2_i     (bus.in_r2),
        .r3_i     (bus.in_r3),
        .shamt_i  (bus.in_shamt),
        .funct_i  (bus.in_funct),
        .lit_i    (bus.in_lit),
        .word_o   (packed_word),
        .legal_o  (packed_legal)
    );

    assign cnt_inc = cnt_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    addr_d  = base_addr;
                    cnt_d   = '0;
                    len_d   = length;
                    err_d   = 1'b0;
                    state_d = (length == '0) ? ST_DONE : ST_ACCEPT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (bus.in_valid) begin
                    if (packed_legal) begin
                        word_d  = packed_word;
                        state_d = ST_WRITE;
                    end else begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = ST_ERROR;
                    end
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? ST_DONE : ST_ACCEPT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == ST_ACCEPT);
    assign bus.imem_we    = (state_q == ST_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word_q;
    assign busy           = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;
    assign err_addr       = err_addr_q;
    assign word_count     = cnt_q;
endmodule

// File: tb/tb_dsp_instr_encoder.sv
// Directed bench for dsp_instr_encoder: per-opcode vector table plus multi-word,
// error, wrap, empty-job and mid-job reset sequences.
module tb_dsp_instr_encoder;
    import dsp_instr_encoder_pkg::*;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  r1, r2, r3, sh;
        logic [5:0]  fn;
        logic [15:0] lit;
        logic [31:0] exp_word;
        logic        legal;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr, length;
    logic        busy, done, err;
    logic [15:0] err_addr, word_count;

    dsp_instr_encoder_if #(.ADDR_W(16), .INST_W(32)) bus ();

    dsp_instr_encoder #(.ADDR_W(16), .INST_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rdy_we_viol = 0;
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    vec_t vecs[12];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            if (bus.in_ready) rdy_we_viol++;
        end
        if (done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [5:0] op, input logic [4:0] r1, r2, r3, sh,
                                 input logic [5:0] fn, input logic [15:0] lit,
                                 input logic [31:0] w, input logic lg);
        vec_t v;
        v.op = op; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.sh = sh;
        v.fn = fn; v.lit = lit; v.exp_word = w; v.legal = lg;
        return v;
    endfunction

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic start_job(input logic [15:0] b, input logic [15:0] l);
        start = 1'b1;
        base_addr = b;
        length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input vec_t v);
        int n;
        bus.in_opcode = v.op; bus.in_r1 = v.r1; bus.in_r2 = v.r2; bus.in_r3 = v.r3;
        bus.in_shamt = v.sh; bus.in_funct = v.fn; bus.in_lit = v.lit;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("handshake_timeout", 32'(n), 32'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(bus.imem_we), 0);
        chk({tag, "_rdy"},   32'(bus.in_ready), 0);
        chk({tag, "_addr"},  32'(bus.imem_addr), 0);
        chk({tag, "_wdata"}, bus.imem_wdata, 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_err"},   32'(err), 0);
        chk({tag, "_eaddr"}, 32'(err_addr), 0);
        chk({tag, "_wcnt"},  32'(word_count), 0);
    endtask

    initial begin
        vec_t a, j, s;
        logic [15:0] b;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_r1 = '0; bus.in_r2 = '0;
        bus.in_r3 = '0; bus.in_shamt = '0; bus.in_funct = '0; bus.in_lit = '0;

        vecs[0]  = mkv(6'b000000,  3,  4,  5,  2,  7, 16'hFFFF, 32'h00642887, 1'b1);
        vecs[1]  = mkv(6'b000010, 31, 31, 31, 31, 63, 16'h0000, 32'h0BFFFFFF, 1'b1);
        vecs[2]  = mkv(6'b000011,  1,  2, 31, 31, 63, 16'hABCD, 32'h0C22ABCD, 1'b1);
        vecs[3]  = mkv(6'b001100,  7,  5,  9,  3,  5, 16'h0000, 32'h30E04800, 1'b1);
        vecs[4]  = mkv(6'b010110,  2,  9,  4,  5,  1, 16'h0000, 32'h58402141, 1'b1);
        vecs[5]  = mkv(6'b011011,  0, 31, 31,  0,  0, 16'h0000, 32'h6C00F800, 1'b1);
        vecs[6]  = mkv(6'b100000, 31,  1,  0,  0,  0, 16'h00FF, 32'h800000FF, 1'b1);
        vecs[7]  = mkv(6'b100010,  5,  6,  0,  0,  0, 16'h8001, 32'h88A08001, 1'b1);
        vecs[8]  = mkv(6'b100011,  1,  3,  0,  0,  0, 16'h0010, 32'h8C230010, 1'b1);
        vecs[9]  = mkv(6'b110100,  4,  2,  7,  9, 11, 16'h1234, 32'hD0820000, 1'b1);
        vecs[10] = mkv(6'b001110,  1,  1,  1,  1,  1, 16'h0001, 32'h0, 1'b0);
        vecs[11] = mkv(6'b111111,  1,  1,  1,  1,  1, 16'h0001, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // single-word jobs, one per opcode class
        for (int i = 0; i < 12; i++) begin
            clear_mon();
            b = 16'h0010 + 16'(i * 16);
            start_job(b, 16'd1);
            send(vecs[i]);
            repeat (3) @(negedge clk);
            if (vecs[i].legal) begin
                chk($sformatf("v%0d_nwr", i), 32'(wr_data.size()), 1);
                if (wr_data.size() > 0) begin
                    chk($sformatf("v%0d_addr", i), 32'(wr_addr[0]), 32'(b));
                    chk($sformatf("v%0d_data", i), wr_data[0], vecs[i].exp_word);
                end
                chk($sformatf("v%0d_done", i), 32'(done_cnt), 1);
                chk($sformatf("v%0d_wcnt", i), 32'(word_count), 1);
                chk($sformatf("v%0d_err", i), 32'(err), 0);
            end else begin
                chk($sformatf("v%0d_nwr", i), 32'(wr_data.size()), 0);
                chk($sformatf("v%0d_err", i), 32'(err), 1);
                chk($sformatf("v%0d_eaddr", i), 32'(err_addr), 32'(b));
                chk($sformatf("v%0d_done", i), 32'(done_cnt), 0);
                chk($sformatf("v%0d_rdy", i), 32'(bus.in_ready), 0);
            end
        end

        // three back-to-back words with field zeroing
        clear_mon();
        a = mkv(6'b000001, 1, 2, 0, 0, 0, 16'h1234, 0, 1'b1);
        j = mkv(6'b100000, 31, 0, 0, 0, 0, 16'h00FF, 0, 1'b1);
        s = mkv(6'b001100, 7, 5, 9, 0, 0, 16'h0000, 0, 1'b1);
        start_job(16'h0000, 16'd3);
        chk("seq_err_cleared", 32'(err), 0);
        send(a); send(j); send(s);
        repeat (3) @(negedge clk);
        chk("seq_nwr", 32'(wr_data.size()), 3);
        if (wr_data.size() == 3) begin
            chk("seq_a0", 32'(wr_addr[0]), 0);
            chk("seq_a1", 32'(wr_addr[1]), 1);
            chk("seq_a2", 32'(wr_addr[2]), 2);
            chk("seq_d0", wr_data[0], 32'h04221234);
            chk("seq_d1", wr_data[1], 32'h800000FF);
            chk("seq_d2", wr_data[2], 32'h30E04800);
        end
        chk("seq_done", 32'(done_cnt), 1);
        chk("seq_wcnt", 32'(word_count), 3);

        // illegal second word stops the job
        clear_mon();
        start_job(16'h0040, 16'd2);
        send(a);
        send(mkv(6'b001110, 0, 0, 0, 0, 0, 16'h0, 0, 1'b0));
        repeat (4) @(negedge clk);
        chk("ill_nwr", 32'(wr_data.size()), 1);
        if (wr_data.size() > 0) chk("ill_addr", 32'(wr_addr[0]), 32'h0040);
        chk("ill_err", 32'(err), 1);
        chk("ill_eaddr", 32'(err_addr), 32'h0041);
        chk("ill_done", 32'(done_cnt), 0);
        chk("ill_busy", 32'(busy), 0);
        chk("ill_wcnt", 32'(word_count), 1);
        start_job(16'h0050, 16'd0);
        chk("restart_err", 32'(err), 0);
        @(negedge clk);

        // address wrap at the top of memory
        clear_mon();
        start_job(16'hFFFF, 16'd2);
        send(a); send(j);
        repeat (3) @(negedge clk);
        chk("wrap_nwr", 32'(wr_data.size()), 2);
        if (wr_data.size() == 2) begin
            chk("wrap_a0", 32'(wr_addr[0]), 32'hFFFF);
            chk("wrap_a1", 32'(wr_addr[1]), 32'h0000);
        end
        chk("wrap_done", 32'(done_cnt), 1);

        // empty job
        clear_mon();
        start_job(16'h0200, 16'd0);
        chk("len0_done", 32'(done), 1);
        chk("len0_rdy", 32'(bus.in_ready), 0);
        chk("len0_busy", 32'(busy), 0);
        @(negedge clk);
        chk("len0_done_off", 32'(done), 0);
        repeat (2) @(negedge clk);
        chk("len0_nwr", 32'(wr_data.size()), 0);
        chk("len0_done_cnt", 32'(done_cnt), 1);

        // reset during a write, with start held alongside
        start_job(16'h0020, 16'd3);
        send(a);
        chk("rst_in_write", 32'(bus.imem_we), 1);
        reset = 1'b1;
        start = 1'b1;
        base_addr = 16'h0030;
        length = 16'd2;
        @(negedge clk);
        chk_all_zero("rst");
        @(negedge clk);
        chk("rst_hold_busy", 32'(busy), 0);
        chk("rst_hold_rdy", 32'(bus.in_ready), 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_after_busy", 32'(busy), 0);
        chk("rst_after_wcnt", 32'(word_count), 0);

        chk("ready_during_write", 32'(rdy_we_viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
